ifu_fetch_queue: RTL and testbench
==================================

// Module: ifu_fetch_queue
// PURPOSE
//  Instruction-fetch stage directly downstream of the PC register. Issues the current
//  PC as an instruction-memory request, tracks in-flight reads, and buffers returned
//  {pc, inst} pairs in order for decode. Holds the PC register through a stall output
//  when no slot is free, and discards stale fetches on a branch/jump redirect.
// PARAMETERS
//  DEPTH   4   queue slots, covering in-flight plus buffered; power of two, >=2
//  XLEN    32  address/instruction width
// PORTS
//  i_clk          in   1     clock, all state updates on rising edge
//  i_reset        in   1     asynchronous, active-high reset
//  i_pc           in   XLEN  current PC from the PC register
//  o_pc_stall     out  1     1 = PC register must hold (request not accepted this cycle)
//  i_flush        in   1     redirect: discard all queued and in-flight fetches
//  o_imem_req     out  1     request valid to instruction memory
//  o_imem_addr    out  XLEN  request address (= i_pc)
//  i_imem_gnt     in   1     request accepted this cycle (transfer = req & gnt)
//  i_imem_rvalid  in   1     read data valid; in order, >=1 cycle after grant
//  i_imem_rdata   in   XLEN  instruction word
//  o_inst_valid   out  1     head slot filled, presented to decode
//  o_inst         out  XLEN  head instruction
//  o_inst_pc      out  XLEN  PC of head instruction
//  i_inst_ready   in   1     decode accepts head (pop = valid & ready)
// BEHAVIOUR
//  - Reset: all pointers 0, drop counter 0, state S_RUN. o_imem_req=0, o_inst_valid=0,
//    o_pc_stall=1, o_inst/o_inst_pc=0. Reset mid-transaction: responses after reset
//    deassertion for pre-reset requests are not expected (memory resets with the core).
//  - Slot FIFO, three pointers, each clog2(DEPTH)+1 bits with wrap bit:
//    alloc (on request transfer, writes pc), fill (on accepted rvalid, writes inst),
//    head (on pop). occupancy = alloc-head; full when occupancy == DEPTH.
//  - o_imem_req = (state==S_RUN) & ~full & ~i_flush. o_imem_addr = i_pc.
//  - o_pc_stall = ~(o_imem_req & i_imem_gnt), combinational.
//  - o_inst_valid = (fill != head); o_inst/o_inst_pc from slot[head]; zero latency from
//    storage; first instruction visible the cycle after its rvalid.
//  - Simultaneous alloc, fill, pop in one cycle: all three apply; full is evaluated on
//    the pre-update occupancy (pop does not free a slot for same-cycle request).
//  - rvalid while fill == alloc in S_RUN is a protocol error: ignored, assertion fires.
//  - FSM:
//    S_RUN:   normal. On i_flush: alloc/fill/head <- 0, drop_cnt <- (alloc-fill) minus
//             1 if rvalid this cycle (that response is discarded);
//             next = S_DRAIN if that drop_cnt != 0, else S_RUN.
//    S_DRAIN: o_imem_req=0, o_inst_valid=0; each rvalid decrements drop_cnt and data
//             is discarded. drop_cnt reaching 0 -> S_RUN. i_flush here: no effect on
//             drop_cnt (queue already empty).
//  - i_flush has priority over pop/alloc/fill in the same cycle; o_inst_valid is
//    still driven from pre-flush state but decode ignores it under flush.
//  - drop_cnt width clog2(DEPTH)+1; never exceeds DEPTH.
// STRUCTURE
//  - Shared package (core_pkg): XLEN, fetch state enum {S_RUN, S_DRAIN}, NOP encoding
//    32'h0000_0013 for decode bubbles.
//  - Single module; slot storage as two XLEN-wide arrays (pc, inst), no sub-modules.
// TESTING
//  1 Reset, gnt=1, rvalid 1 cycle after each grant, ready=1, pc 0,4,8.. -> inst out
//    in order with o_inst_pc 0,4,8; o_pc_stall=0 every cycle after first request.
//  2 ready=0, gnt=1, DEPTH=4 -> exactly 4 requests issued, then o_imem_req=0,
//    o_pc_stall=1; ready=1 for one cycle -> one pop, one new request next cycle.
//  3 gnt=0 for 3 cycles with i_pc=0x40 -> o_pc_stall=1, no alloc; gnt=1 -> one
//    request addr 0x40, o_pc_stall=0.
//  4 Three requests outstanding (0x10,0x14,0x18), i_flush -> queue empty, S_DRAIN,
//    req=0; three rvalid dropped, o_inst_valid stays 0; then S_RUN, i_pc=0x80 issued.
//  5 i_flush coincident with rvalid, 2 outstanding -> drop_cnt=1; one later rvalid
//    dropped, return to S_RUN; no stale instruction reaches decode.
//  6 Async reset asserted mid-stream between clock edges -> outputs reach reset values
//    immediately, before the next rising edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: data width, fetch-stage state encoding, decode bubble.
package core_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic {
      S_RUN   = 1'b0,
      S_DRAIN = 1'b1
   } fetch_state_t;

   // addi x0, x0, 0 -- inserted by decode as a bubble
   localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue: issues PC requests to instruction memory, tracks
// in-flight reads and buffers returned {pc, inst} pairs in order for decode.
// A redirect empties the queue and silently swallows responses still in flight.
module ifu_fetch_queue
   import core_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = core_pkg::XLEN
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [XLEN-1:0] i_pc,
   output logic            o_pc_stall,
   input  logic            i_flush,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [XLEN-1:0] i_imem_rdata,
   output logic            o_inst_valid,
   output logic [XLEN-1:0] o_inst,
   output logic [XLEN-1:0] o_inst_pc,
   input  logic            i_inst_ready
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned PW = IW + 1;

   fetch_state_t    state;
   logic [PW-1:0]   alloc_ptr;
   logic [PW-1:0]   fill_ptr;
   logic [PW-1:0]   head_ptr;
   logic [PW-1:0]   drop_cnt;
   logic [XLEN-1:0] slot_pc   [DEPTH];
   logic [XLEN-1:0] slot_inst [DEPTH];

   logic [PW-1:0]   occupancy;
   logic [PW-1:0]   flush_drop;
   logic            full;
   logic            in_flight;
   logic            inst_valid;
   logic            alloc_en;
   logic            fill_en;
   logic            pop_en;

   // Occupancy counts in-flight plus buffered slots; pop never frees a slot
   // for a request in the same cycle.
   assign occupancy  = alloc_ptr - head_ptr;
   assign full       = (occupancy == PW'(DEPTH));
   assign in_flight  = (fill_ptr != alloc_ptr);

   // Request / stall handshake with the PC register and memory
   assign o_imem_req  = ~i_reset & (state == S_RUN) & ~full & ~i_flush;
   assign o_imem_addr = i_pc;
   assign o_pc_stall  = ~(o_imem_req & i_imem_gnt);

   // Head presentation straight from slot storage
   assign inst_valid   = (state == S_RUN) & (fill_ptr != head_ptr);
   assign o_inst_valid = inst_valid;
   assign o_inst       = slot_inst[head_ptr[IW-1:0]];
   assign o_inst_pc    = slot_pc[head_ptr[IW-1:0]];

   // Pointer advance enables; flush overrides everything in the same cycle
   assign alloc_en = o_imem_req & i_imem_gnt;
   assign fill_en  = (state == S_RUN) & ~i_flush & i_imem_rvalid & in_flight;
   assign pop_en   = inst_valid & i_inst_ready & ~i_flush;

   // Responses still owed after a redirect; a response arriving with the flush
   // is already consumed.
   assign flush_drop = (alloc_ptr - fill_ptr) - PW'(i_imem_rvalid & in_flight);

   // Fetch state machine, queue pointers and drop counter
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= S_RUN;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         drop_cnt  <= '0;
      end else begin
         case (state)
            S_RUN: begin
               if (i_flush) begin
                  alloc_ptr <= '0;
                  fill_ptr  <= '0;
                  head_ptr  <= '0;
                  drop_cnt  <= flush_drop;
                  state     <= (flush_drop != '0) ? S_DRAIN : S_RUN;
               end else begin
                  if (alloc_en) alloc_ptr <= alloc_ptr + PW'(1);
                  if (fill_en)  fill_ptr  <= fill_ptr + PW'(1);
                  if (pop_en)   head_ptr  <= head_ptr + PW'(1);
               end
            end
            S_DRAIN: begin
               if (i_imem_rvalid) begin
                  drop_cnt <= drop_cnt - PW'(1);
                  if (drop_cnt == PW'(1)) state <= S_RUN;
               end
            end
         endcase
      end
   end

   // Slot storage: pc written on request transfer, instruction on response
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            slot_pc[i]   <= '0;
            slot_inst[i] <= '0;
         end
      end else begin
         if (alloc_en) slot_pc[alloc_ptr[IW-1:0]]  <= i_pc;
         if (fill_en)  slot_inst[fill_ptr[IW-1:0]] <= i_imem_rdata;
      end
   end

   // A response with nothing in flight means memory broke the protocol
   a_no_orphan_rvalid : assert property (
      @(posedge i_clk) disable iff (i_reset)
      ((state == S_RUN) && i_imem_rvalid) |-> in_flight
   );

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: directed phases plus random traffic, compared
// cycle by cycle against a queue-of-slots reference and a memory model.
module tb_ifu_fetch_queue;

   localparam int DEPTH = 4;

   logic        i_clk;
   logic        i_reset;
   logic [31:0] i_pc;
   logic        o_pc_stall;
   logic        i_flush;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        o_inst_valid;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        i_inst_ready;

   ifu_fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_pc          (i_pc),
      .o_pc_stall    (o_pc_stall),
      .i_flush       (i_flush),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (i_imem_gnt),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .o_inst_valid  (o_inst_valid),
      .o_inst        (o_inst),
      .o_inst_pc     (o_inst_pc),
      .i_inst_ready  (i_inst_ready)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      bit          filled;
   } slot_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } mem_t;

   slot_t mq[$];      // reference queue: every granted fetch, oldest first
   mem_t  mem_q[$];   // memory model: responses still owed, in order
   bit    draining;
   int    drop_left;
   int    cyc;
   int    total;
   int    bad;
   int    xfers;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mem_q.delete();
      draining  = 0;
      drop_left = 0;
   endtask

   // One clock: called at a falling edge, drives inputs, checks, then updates models.
   // rvmode: 0 = never respond, 1 = respond whenever allowed, 2 = random.
   task automatic cycle(input bit gnt, input bit rdy, input bit fl, input int rvmode,
                        input logic [31:0] pc);
      bit          rv;
      bit          m_req;
      bit          m_valid;
      logic [31:0] rd;
      rv = 0;
      rd = $urandom;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc)
         rv = (rvmode == 1) || (rvmode == 2 && $urandom_range(0, 1) == 1);
      if (rv) rd = mem_q[0].data;
      i_pc          = pc;
      i_imem_gnt    = gnt;
      i_inst_ready  = rdy;
      i_flush       = fl;
      i_imem_rvalid = rv;
      i_imem_rdata  = rd;
      #1;
      m_req   = !draining && (mq.size() < DEPTH) && !fl;
      m_valid = !draining && (mq.size() > 0) && mq[0].filled;
      chk("imem_req",   32'(o_imem_req),   32'(m_req));
      chk("pc_stall",   32'(o_pc_stall),   32'(!(m_req && gnt)));
      chk("imem_addr",  o_imem_addr,       pc);
      chk("inst_valid", 32'(o_inst_valid), 32'(m_valid));
      if (m_valid) begin
         chk("inst",    o_inst,    mq[0].inst);
         chk("inst_pc", o_inst_pc, mq[0].pc);
      end
      if (o_imem_req && gnt) xfers++;
      @(posedge i_clk);
      if (fl && !draining) begin
         int unfilled;
         unfilled = 0;
         foreach (mq[i]) if (!mq[i].filled) unfilled++;
         drop_left = unfilled - (rv ? 1 : 0);
         mq.delete();
         draining = (drop_left != 0);
      end else if (draining) begin
         if (rv) begin
            drop_left--;
            if (drop_left == 0) draining = 0;
         end
      end else begin
         if (rv) begin
            for (int i = 0; i < mq.size(); i++) begin
               if (!mq[i].filled) begin
                  slot_t s;
                  s = mq[i];
                  s.inst = rd;
                  s.filled = 1;
                  mq[i] = s;
                  break;
               end
            end
         end
         if (m_valid && rdy) void'(mq.pop_front());
         if (m_req && gnt) begin
            slot_t s;
            s.pc = pc;
            s.inst = '0;
            s.filled = 0;
            mq.push_back(s);
         end
      end
      if (rv) void'(mem_q.pop_front());
      if (m_req && gnt) begin
         mem_t m;
         m.data = $urandom;
         m.due  = cyc + 1;
         mem_q.push_back(m);
      end
      cyc++;
      @(negedge i_clk);
   endtask

   task automatic check_reset_outputs(input string pfx);
      chk({pfx, "_req"},   32'(o_imem_req),   32'd0);
      chk({pfx, "_stall"}, 32'(o_pc_stall),   32'd1);
      chk({pfx, "_valid"}, 32'(o_inst_valid), 32'd0);
      chk({pfx, "_inst"},  o_inst,            32'd0);
      chk({pfx, "_ipc"},   o_inst_pc,         32'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      xfers = 0;
      model_reset();
      i_reset       = 1'b1;
      i_pc          = '0;
      i_flush       = 1'b0;
      i_imem_gnt    = 1'b1;
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = '0;
      i_inst_ready  = 1'b1;
      #3;
      check_reset_outputs("reset");
      @(negedge i_clk);
      i_reset = 1'b0;

      // Streaming: full grant, one-cycle memory, decode always ready
      for (int i = 0; i < 10; i++) cycle(1, 1, 0, 1, 32'(i * 4));

      // Drain, then back-pressure from decode fills all slots
      for (int i = 0; i < 12; i++) cycle(0, 1, 0, 1, 32'h100);
      xfers = 0;
      for (int i = 0; i < 8; i++) cycle(1, 0, 0, 1, 32'h200 + 32'(i * 4));
      chk("bp_requests", 32'(xfers), 32'd4);
      cycle(1, 1, 0, 1, 32'h220);
      xfers = 0;
      cycle(1, 0, 0, 1, 32'h224);
      chk("bp_one_more", 32'(xfers), 32'd1);

      // Memory refuses grant: PC held, then accepted
      for (int i = 0; i < 12; i++) cycle(0, 1, 0, 1, 32'h100);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, 32'h40);
      xfers = 0;
      cycle(1, 1, 0, 0, 32'h40);
      chk("gnt_accept", 32'(xfers), 32'd1);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1, 32'h44);

      // Redirect with three fetches outstanding
      cycle(1, 1, 0, 0, 32'h10);
      cycle(1, 1, 0, 0, 32'h14);
      cycle(1, 1, 0, 0, 32'h18);
      cycle(1, 1, 1, 0, 32'h1c);
      chk("flush3_drop", 32'(drop_left), 32'd3);
      for (int i = 0; i < 3; i++) cycle(1, 1, 0, 1, 32'h80);
      xfers = 0;
      cycle(1, 1, 0, 0, 32'h80);
      chk("flush3_resume", 32'(xfers), 32'd1);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1, 32'h84);

      // Redirect coinciding with a response, two outstanding
      cycle(1, 1, 0, 0, 32'h20);
      cycle(1, 1, 0, 0, 32'h24);
      cycle(0, 1, 1, 1, 32'h28);
      for (int i = 0; i < 3; i++) cycle(1, 1, 0, 1, 32'h90);

      // Random traffic with occasional redirects
      for (int i = 0; i < 400; i++)
         cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) != 0),
               bit'($urandom_range(0, 15) == 0), 2, {$urandom_range(0, 255), 2'b00});

      // Asynchronous reset between edges with traffic in flight
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 2, 32'h300 + 32'(i * 4));
      i_pc         = 32'h400;
      i_imem_gnt   = 1'b1;
      i_inst_ready = 1'b1;
      i_flush      = 1'b0;
      #2;
      i_reset       = 1'b1;
      i_imem_rvalid = 1'b0;
      #1;
      check_reset_outputs("async");
      @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
      model_reset();
      for (int i = 0; i < 40; i++)
         cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 19) == 0), 2, 32'h500 + 32'(i * 4));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
